fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_src_sel.sv | 88 ++++++++
 rtl/fwd_hazard_unit.sv | 139 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding / hazard unit.
// Source codes, FSM states and register index width.
package fwd_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    REG       = 3'd0,
    EXMEM_ALU = 3'd1,
    MEM_RDATA = 3'd2,
    HOLD      = 3'd3,
    WB        = 3'd4
  } fwd_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fwd_state_t;

  function automatic logic idx_hit(
    input logic                 en,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs
  );
    return en && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source forwarding select with a one-shot WB hold register.
// Ports: rs idx/data, EX/MEM and MEM/WB bypass inputs, global stall -> opnd, sel, load_wait.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic [XLEN-1:0]      rs_data,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic                 mem_ld,
  input  logic                 mem_is_load,
  input  logic [XLEN-1:0]      mem_alu,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_resp,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_ld,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 stall,
  output logic [XLEN-1:0]      opnd,
  output fwd_src_t             sel,
  output logic                 load_wait
);

  logic            hold_vld_q, hold_vld_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            mem_hit, wb_hit;
  logic            c_alu, c_mrd, c_lw, c_hold, c_wb;

  always_comb begin
    mem_hit = idx_hit(mem_ld, mem_rd, rs_idx);
    wb_hit  = idx_hit(wb_ld, wb_rd, rs_idx);
    // Mutually exclusive terms encoding the priority chain
    c_alu  = mem_hit & ~mem_is_load;
    c_mrd  = mem_hit & mem_is_load & mem_resp;
    c_lw   = mem_hit & mem_is_load & ~mem_resp;
    c_hold = ~mem_hit & hold_vld_q & (rs_idx != '0);
    c_wb   = ~mem_hit & ~hold_vld_q & wb_hit;
    sel       = REG;
    opnd      = rs_data;
    load_wait = 1'b0;
    unique case (1'b1)
      c_alu: begin
        sel  = EXMEM_ALU;
        opnd = mem_alu;
      end
      c_mrd: begin
        sel  = MEM_RDATA;
        opnd = mem_rdata;
      end
      c_lw:   load_wait = 1'b1;
      c_hold: begin
        sel  = HOLD;
        opnd = hold_q;
      end
      c_wb: begin
        sel  = WB;
        opnd = wb_data;
      end
      default: ;
    endcase
  end

  // WB drains while EX is frozen: catch its value once, keep it
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (!stall) begin
      hold_vld_d = 1'b0;
    end else if (wb_hit && !hold_vld_q) begin
      hold_vld_d = 1'b1;
      hold_d     = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, load-use stall and stall watchdog.
// Ports: packed EX sources, bypass buses -> ex_opnd/ex_sel, stall, timeout_err (+stats with FWD_STATS_EN).
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ex_valid,
  input  logic [NUM_SRC*REG_IDX_W-1:0]   ex_rs_idx,
  input  logic [NUM_SRC*XLEN-1:0]        ex_rs_data,
  input  logic [REG_IDX_W-1:0]           mem_rd,
  input  logic                           mem_ld,
  input  logic                           mem_is_load,
  input  logic [XLEN-1:0]                mem_alu,
  input  logic [XLEN-1:0]                mem_rdata,
  input  logic                           mem_resp,
  input  logic [REG_IDX_W-1:0]           wb_rd,
  input  logic                           wb_ld,
  input  logic [XLEN-1:0]                wb_data,
  output logic [NUM_SRC*XLEN-1:0]        ex_opnd,
  output logic [NUM_SRC*3-1:0]           ex_sel,
  output logic                           stall,
  output logic                           timeout_err
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                    stat_fwd_cnt,
  output logic [31:0]                    stat_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [NUM_SRC-1:0] lw;
  fwd_src_t           sel_w [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(.XLEN(XLEN)) u_sel (
      .clk         (clk),
      .rst         (rst),
      .rs_idx      (ex_rs_idx[REG_IDX_W*i +: REG_IDX_W]),
      .rs_data     (ex_rs_data[XLEN*i +: XLEN]),
      .mem_rd      (mem_rd),
      .mem_ld      (mem_ld),
      .mem_is_load (mem_is_load),
      .mem_alu     (mem_alu),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .wb_rd       (wb_rd),
      .wb_ld       (wb_ld),
      .wb_data     (wb_data),
      .stall       (stall),
      .opnd        (ex_opnd[XLEN*i +: XLEN]),
      .sel         (sel_w[i]),
      .load_wait   (lw[i])
    );
    assign ex_sel[3*i +: 3] = sel_w[i];
  end

  assign stall = ex_valid & (|lw);

  fwd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!stall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    err_d = err_q | (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign timeout_err = err_q;

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stl_cnt_q, stl_cnt_d;
  logic        any_fwd;

  always_comb begin
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      any_fwd = any_fwd | (sel_w[i] != REG);
    end
    fwd_cnt_d = fwd_cnt_q;
    stl_cnt_d = stl_cnt_q;
    if (ex_valid && !stall && any_fwd) fwd_cnt_d = fwd_cnt_q + 32'd1;
    if (stall) stl_cnt_d = stl_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign stat_fwd_cnt   = fwd_cnt_q;
  assign stat_stall_cnt = stl_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (3 sources, short watchdog).
// Directed scenarios plus randomized traffic against a reference model.
module tb_fwd_hazard_unit;

  localparam int N   = 3;
  localparam int W   = 32;
  localparam int TMO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ex_valid;
  logic [N*5-1:0]   ex_rs_idx;
  logic [N*W-1:0]   ex_rs_data;
  logic [4:0]       mem_rd;
  logic             mem_ld, mem_is_load;
  logic [W-1:0]     mem_alu, mem_rdata;
  logic             mem_resp;
  logic [4:0]       wb_rd;
  logic             wb_ld;
  logic [W-1:0]     wb_data;
  logic [N*W-1:0]   ex_opnd;
  logic [N*3-1:0]   ex_sel;
  logic             stall;
  logic             timeout_err;

  fwd_hazard_unit #(.NUM_SRC(N), .XLEN(W), .TIMEOUT(TMO)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_rs_idx   (ex_rs_idx),
    .ex_rs_data  (ex_rs_data),
    .mem_rd      (mem_rd),
    .mem_ld      (mem_ld),
    .mem_is_load (mem_is_load),
    .mem_alu     (mem_alu),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .wb_rd       (wb_rd),
    .wb_ld       (wb_ld),
    .wb_data     (wb_data),
    .ex_opnd     (ex_opnd),
    .ex_sel      (ex_sel),
    .stall       (stall),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  bit          m_hv [N];
  logic [31:0] m_hd [N];
  int          m_run;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 1'b0;
      m_hd[i] = '0;
    end
    m_run = 0;
    m_err = 1'b0;
  endtask

  function automatic void ref_src(input int i, output logic [2:0] s,
                                  output logic [31:0] v, output bit lw);
    logic [4:0] rs;
    bit mm, wm;
    rs = ex_rs_idx[5*i +: 5];
    mm = mem_ld && mem_rd != 0 && mem_rd == rs;
    wm = wb_ld && wb_rd != 0 && wb_rd == rs;
    s  = 3'd0;
    v  = ex_rs_data[W*i +: W];
    lw = 1'b0;
    if (rs == 0) begin
    end else if (mm && !mem_is_load) begin
      s = 3'd1; v = mem_alu;
    end else if (mm && mem_resp) begin
      s = 3'd2; v = mem_rdata;
    end else if (mm) begin
      lw = 1'b1;
    end else if (m_hv[i]) begin
      s = 3'd3; v = m_hd[i];
    end else if (wm) begin
      s = 3'd4; v = wb_data;
    end
  endfunction

  task automatic tick();
    logic [2:0]  s;
    logic [31:0] v;
    bit          lw, st;
    logic [4:0]  rs;
    @(negedge clk);
    st = 1'b0;
    for (int i = 0; i < N; i++) begin
      ref_src(i, s, v, lw);
      if (lw) st = 1'b1;
      chk($sformatf("sel%0d", i), 32'(ex_sel[3*i +: 3]), 32'(s));
      chk($sformatf("opnd%0d", i), ex_opnd[W*i +: W], v);
    end
    st = st && ex_valid;
    chk("stall", 32'(stall), 32'(st));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    @(posedge clk);
    if (rst) begin
      if (st) begin
        for (int i = 0; i < N; i++) begin
          rs = ex_rs_idx[5*i +: 5];
          if (wb_ld && wb_rd != 0 && wb_rd == rs && !m_hv[i]) begin
            m_hv[i] = 1'b1;
            m_hd[i] = wb_data;
          end
        end
        m_run++;
        if (m_run >= TMO) m_err = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic clear_in();
    ex_valid    = 1'b1;
    ex_rs_idx   = '0;
    for (int i = 0; i < N; i++) ex_rs_data[W*i +: W] = 32'h100 + 32'(i);
    mem_rd      = '0;
    mem_ld      = 1'b0;
    mem_is_load = 1'b0;
    mem_alu     = 32'hA1A1;
    mem_rdata   = 32'hD0D0;
    mem_resp    = 1'b0;
    wb_rd       = '0;
    wb_ld       = 1'b0;
    wb_data     = 32'hB0B0;
  endtask

  task automatic set_rs(input int i, input logic [4:0] r);
    ex_rs_idx[5*i +: 5] = r;
  endtask

  task automatic load_at_mem(input logic [4:0] r, input logic resp,
                             input logic [31:0] d);
    mem_rd = r; mem_ld = 1'b1; mem_is_load = 1'b1;
    mem_resp = resp; mem_rdata = d;
  endtask

  function automatic logic [4:0] pick_idx();
    if ($urandom_range(0, 7) < 6) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    clear_in();
    model_reset();
    rst = 1'b0;
    #1;
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // ALU result forwarded from EX/MEM
    clear_in();
    set_rs(0, 5'd5);
    mem_rd = 5'd5; mem_ld = 1'b1; mem_alu = 32'h11;
    tick();
    chk("alu_sel", 32'(ex_sel[2:0]), 32'd1);
    chk("alu_opnd", ex_opnd[W-1:0], 32'h11);

    // load-use on source 1 for three cycles, then data arrives
    clear_in();
    set_rs(1, 5'd7);
    load_at_mem(5'd7, 1'b0, 32'h0);
    repeat (3) tick();
    load_at_mem(5'd7, 1'b1, 32'hABCD);
    tick();
    chk("ld_sel", 32'(ex_sel[5:3]), 32'd2);
    chk("ld_opnd", ex_opnd[2*W-1:W], 32'hABCD);
    chk("ld_stall", 32'(stall), 32'd0);

    // WB value captured while frozen, later WB ignored
    clear_in();
    set_rs(1, 5'd7);
    load_at_mem(5'd7, 1'b0, 32'h0);
    set_rs(0, 5'd9);
    wb_rd = 5'd9; wb_ld = 1'b1; wb_data = 32'h55;
    tick();
    wb_data = 32'h66;
    #0;
    chk("hold_sel", 32'(ex_sel[2:0]), 32'd3);
    chk("hold_opnd", ex_opnd[W-1:0], 32'h55);
    tick();
    mem_resp = 1'b1;
    tick();
    tick();
    chk("hold_clr", 32'(ex_sel[2:0]), 32'd4);

    // x0 never forwarded
    clear_in();
    mem_rd = 5'd0; mem_ld = 1'b1;
    tick();
    chk("x0_sel", 32'(ex_sel[2:0]), 32'd0);

    // all sources waiting on the same load
    clear_in();
    for (int i = 0; i < N; i++) set_rs(i, 5'd12);
    load_at_mem(5'd12, 1'b0, 32'h0);
    tick();
    load_at_mem(5'd12, 1'b1, 32'h1234);
    tick();

    // reset in the middle of a stall drops captured holds
    clear_in();
    set_rs(1, 5'd7);
    load_at_mem(5'd7, 1'b0, 32'h0);
    set_rs(0, 5'd9);
    wb_rd = 5'd9; wb_ld = 1'b1; wb_data = 32'h77;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    wb_data = 32'h88;
    tick();
    rst = 1'b1;
    mem_resp = 1'b1;
    tick();

    // watchdog: sticky until reset
    clear_in();
    set_rs(0, 5'd3);
    load_at_mem(5'd3, 1'b0, 32'h0);
    repeat (4) tick();
    chk("wd_set", 32'(timeout_err), 32'd1);
    repeat (2) tick();
    mem_resp = 1'b1;
    repeat (2) tick();
    chk("wd_sticky", 32'(timeout_err), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("wd_clr", 32'(timeout_err), 32'd0);
    tick();
    rst = 1'b1;

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      ex_valid = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        set_rs(i, pick_idx());
        ex_rs_data[W*i +: W] = $urandom;
      end
      mem_rd      = pick_idx();
      mem_ld      = ($urandom_range(0, 3) != 0);
      mem_is_load = $urandom_range(0, 1) == 1;
      mem_alu     = $urandom;
      mem_rdata   = $urandom;
      mem_resp    = ($urandom_range(0, 2) == 0);
      wb_rd       = pick_idx();
      wb_ld       = ($urandom_range(0, 3) != 0);
      wb_data     = $urandom;
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
